// File: rtl/sp_mem_ctrl_pkg.sv
// sp_mem_ctrl_pkg: shared types and constants for the sp_mem_ctrl slice.
package sp_mem_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sp_mem_ctrl_state_e;

    // Response buffer entries; with a one-cycle memory this covers a full
    // round trip so reads stream at one per cycle.
    localparam int RSP_DEPTH = 2;

endpackage

// File: rtl/sp_mem_ctrl_rsp_fifo.sv
// sp_mem_ctrl_rsp_fifo: 2-entry synchronous FIFO holding read responses.
// Entries and occupancy are flops, so head/occ are glitch-free registered
// values that only change on a push or pop.
module sp_mem_ctrl_rsp_fifo
    import sp_mem_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] ent_q [RSP_DEPTH];
    logic [WIDTH-1:0] ent_d [RSP_DEPTH];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             pop_ok;

    assign pop_ok = pop && (occ_q != 2'd0);

    // Next-state for entries, pointers and occupancy. A push into a full
    // FIFO is only issued together with a pop, in which case the write
    // slot is the one being freed.
    always_comb begin
        ent_d    = ent_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            ent_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop_ok};
    end

    // State registers; reset empties the FIFO and zeroes the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            ent_q    <= ent_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = ent_q[rd_ptr_q];

endmodule

// File: rtl/sp_mem_ctrl.sv
// sp_mem_ctrl: valid/ready request front end for the single-port
// byte-enable memory. Absorbs the one-cycle read latency and buffers read
// data in a 2-entry FIFO so response backpressure never drops data.
// Build option SP_MEM_CTRL_INIT_EN: zero-fill the memory after reset.
//
// state   | meaning
// ST_INIT | sweeping zeros into addresses 0..DEPTH-1, requests blocked
// ST_RUN  | requests pass straight through to the memory pins
module sp_mem_ctrl
    import sp_mem_ctrl_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [AW-1:0]      req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [WIDTH/8-1:0] req_wstrb,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               init_done,
    output logic               mem_cs,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [WIDTH/8-1:0] mem_wstrb,
    input  logic [WIDTH-1:0]   mem_rdata
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    sp_mem_ctrl_state_e state;
    logic               accept;
    logic               in_range;
    logic               pop;
    logic               credit_ok;
    logic [1:0]         occ;
    logic [2:0]         used;
    logic               infl_q, infl_d;
    logic               oob_q, oob_d;
    logic [WIDTH-1:0]   push_data;

`ifdef SP_MEM_CTRL_INIT_EN
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    sp_mem_ctrl_state_e state_q, state_d;
    logic [AW-1:0]      init_addr_q, init_addr_d;

    // Init sweep: one zero write per cycle, leave ST_INIT after the last.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == ST_INIT) begin
            init_addr_d = init_addr_q + AW'(1);
            if (init_addr_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    // FSM and sweep address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    assign state     = state_q;
    assign init_done = (state_q == ST_RUN);
`else
    assign state     = ST_RUN;
    assign init_done = 1'b1;
`endif

    assign in_range = ({1'b0, req_addr} < DEPTH_W);
    assign pop      = rsp_valid && rsp_ready;

    // Credit check: FIFO slots already owed (stored + read in flight) less
    // the one leaving this cycle must leave room for a new read. Outputs
    // are held idle combinationally while reset is asserted.
    always_comb begin
        used      = {1'b0, occ} + {2'b00, infl_q};
        credit_ok = (used < (3'd2 + {2'b00, pop}));
        req_ready = rst_n && (state == ST_RUN) && (req_we || credit_ok);
        accept    = req_valid && req_ready;
        infl_d    = accept && !req_we;
        oob_d     = !in_range;
    end

    // Memory pin mux: init sweep or pass-through of the accepted request.
    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        mem_wstrb = req_wstrb;
        if (rst_n) begin
`ifdef SP_MEM_CTRL_INIT_EN
            if (state == ST_INIT) begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = init_addr_q;
                mem_wdata = '0;
                mem_wstrb = '1;
            end else begin
                mem_cs = accept && in_range;
                mem_we = req_we;
            end
`else
            mem_cs = accept && in_range;
            mem_we = req_we;
`endif
        end
    end

    // Track the read issued last cycle and whether it skipped the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q <= 1'b0;
            oob_q  <= 1'b0;
        end else begin
            infl_q <= infl_d;
            oob_q  <= oob_d;
        end
    end

    assign push_data = oob_q ? '0 : mem_rdata;

    sp_mem_ctrl_rsp_fifo #(
        .WIDTH(WIDTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (infl_q),
        .push_data(push_data),
        .pop      (pop),
        .occ      (occ),
        .head     (rsp_rdata)
    );

    assign rsp_valid = (occ != 2'd0);

endmodule

// File: tb/tb_sp_mem_ctrl.sv
// tb_sp_mem_ctrl: directed and random checks of sp_mem_ctrl against a
// word-array memory model and a queue of expected read responses.
module tb_sp_mem_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 12;
    localparam int AW    = $clog2(DEPTH);
    localparam int SW    = WIDTH / 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_we = 1'b0;
    logic [AW-1:0]    req_addr = '0;
    logic [WIDTH-1:0] req_wdata = '0;
    logic [SW-1:0]    req_wstrb = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_rdata;
    logic             init_done;
    logic             mem_cs;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [SW-1:0]    mem_wstrb;
    logic [WIDTH-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    sp_mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: byte-enable writes, registered one-cycle reads.
    logic [WIDTH-1:0] mem_arr [DEPTH];
    logic [WIDTH-1:0] pre_arr [DEPTH];
    logic             do_preload = 1'b0;

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < DEPTH; i++) mem_arr[i] <= pre_arr[i];
        end else if (mem_cs && (int'(mem_addr) < DEPTH)) begin
            if (mem_we) begin
                for (int b = 0; b < SW; b++)
                    if (mem_wstrb[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem_arr[mem_addr];
            end
        end
    end

    // Reference: what each address should hold, and responses owed in order.
    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] exp_q [$];
    logic             hold = 1'b0;
    logic [WIDTH-1:0] hold_data = '0;
    int               cyc = 0;
    int               n_pops = 0;
    int               pop_first = -1;
    int               pop_last = -1;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, observe settled outputs, update model.
    task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] d, input logic [SW-1:0] s,
                        input logic rr, output logic acc, output logic pp);
        logic inr;
        @(negedge clk);
        req_valid = v; req_we = we; req_addr = a;
        req_wdata = d; req_wstrb = s; rsp_ready = rr;
        #1;
        cyc++;
        acc = req_valid && req_ready;
        pp  = rsp_valid && rsp_ready;
        inr = (int'(a) < DEPTH);
        if (hold) begin
            chk("rsp_valid_held", rsp_valid, 1);
            chk("rsp_rdata_held", rsp_rdata, hold_data);
        end
        chk("mem_cs", mem_cs, acc && inr);
        if (mem_cs) begin
            chk("mem_we", mem_we, we);
            chk("mem_addr", mem_addr, a);
        end
        if (pp) begin
            chk("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
            n_pops++;
            if (pop_first < 0) pop_first = cyc;
            pop_last = cyc;
        end
        if (acc) begin
            if (we) begin
                if (inr)
                    for (int b = 0; b < SW; b++)
                        if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            end else begin
                exp_q.push_back(inr ? ref_mem[a] : '0);
            end
        end
        hold      = rsp_valid && !rsp_ready;
        hold_data = rsp_rdata;
    endtask

    task automatic idle(input logic rr);
        logic acc, pp;
        step(1'b0, 1'b0, '0, '0, '0, rr, acc, pp);
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) idle(1'b1);
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_rsp_valid", rsp_valid, 0);
    endtask

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) begin
            pre_arr[i] = $urandom | 32'h1;
            ref_mem[i] = pre_arr[i];
        end
        @(negedge clk); do_preload = 1'b1;
        @(negedge clk); do_preload = 1'b0;
    endtask

    // Assert reset mid-cycle, check idle outputs, release on a negedge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_mem_we", mem_we, 0);
`ifdef SP_MEM_CTRL_INIT_EN
        chk("rst_init_done", init_done, 0);
`else
        chk("rst_init_done", init_done, 1);
`endif
        exp_q.delete();
        hold = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
`ifdef SP_MEM_CTRL_INIT_EN
        req_valid = 1'b1;
        for (int c = 0; c <= DEPTH; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (c == DEPTH) req_valid = 1'b0;
                #1;
            end
            chk("init_done_cycle", init_done, c == DEPTH);
            if (c < DEPTH) begin
                chk("init_req_ready", req_ready, 0);
                chk("init_mem_cs", mem_cs, 1);
                chk("init_mem_we", mem_we, 1);
                chk("init_mem_addr", mem_addr, c);
                chk("init_mem_wdata", mem_wdata, 0);
                chk("init_mem_wstrb", mem_wstrb, {SW{1'b1}});
            end
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
        chk("run_init_done", init_done, 1);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc, pp;
        int   idx, n_acc;

        preload();
        do_reset();

        // Full write then read-back with two-cycle response latency.
        step(1, 1, AW'(5), 32'hDEADBEEF, 4'hF, 1, acc, pp); chk("t1_wr_acc", acc, 1);
        step(1, 0, AW'(5), '0, '0, 1, acc, pp);             chk("t1_rd_acc", acc, 1);
        idle(1); chk("t1_valid_n1", rsp_valid, 0);
        idle(1); chk("t1_valid_n2", rsp_valid, 1); chk("t1_data", rsp_rdata, 32'hDEADBEEF);

        // Partial-strobe merge.
        step(1, 1, AW'(7), 32'h11223344, 4'hF, 1, acc, pp);
        step(1, 1, AW'(7), 32'hAABBCCDD, 4'h5, 1, acc, pp);
        step(1, 0, AW'(7), '0, '0, 1, acc, pp);
        idle(1);
        idle(1); chk("t2_valid", rsp_valid, 1); chk("t2_data", rsp_rdata, 32'h11BB33DD);
        drain();

        // Backpressure: only two reads fit while responses are blocked.
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, AW'(idx), '0, '0, 0, acc, pp);
            if (acc) idx++;
        end
        chk("t3_accepts_blocked", idx, 2);
        chk("t3_ready_low", req_ready, 0);
        chk("t3_valid_high", rsp_valid, 1);
        n_pops = 0;
        for (int i = 0; i < 20 && idx < 4; i++) begin
            step(1, 0, AW'(idx), '0, '0, 1, acc, pp);
            if (acc) idx++;
        end
        chk("t3_all_accepted", idx, 4);
        drain();
        chk("t3_responses", n_pops, 4);

        // Streaming: 16 reads in 16 cycles, 16 back-to-back responses.
        n_acc = 0; n_pops = 0; pop_first = -1; pop_last = -1;
        for (int i = 0; i < 16; i++) begin
            step(1, 0, AW'(i % DEPTH), '0, '0, 1, acc, pp);
            if (acc) n_acc++;
        end
        drain();
        chk("t4_accepts", n_acc, 16);
        chk("t4_responses", n_pops, 16);
        chk("t4_rsp_span", pop_last - pop_first, 15);

        // Out-of-range address: no memory access, read returns zero.
        step(1, 1, AW'(13), 32'hCAFEF00D, 4'hF, 1, acc, pp);
        chk("t5_wr_acc", acc, 1); chk("t5_wr_cs", mem_cs, 0);
        step(1, 0, AW'(13), '0, '0, 1, acc, pp);
        chk("t5_rd_acc", acc, 1); chk("t5_rd_cs", mem_cs, 0);
        idle(1);
        idle(1); chk("t5_valid", rsp_valid, 1); chk("t5_data", rsp_rdata, 0);
        drain();

        // Reset with two responses pending, then read every address.
        step(1, 0, AW'(1), '0, '0, 0, acc, pp);
        step(1, 0, AW'(2), '0, '0, 0, acc, pp);
        idle(0);
        idle(0);
        chk("t6_pending", exp_q.size(), 2);
        preload();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 0, AW'(i), '0, '0, 1, acc, pp);
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, (1 << AW) - 1)), $urandom, SW'($urandom),
                 $urandom_range(0, 3) != 0, acc, pp);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sp_mem_ctrl.md
# sp_mem_ctrl

Request/response front end for the single-port byte-enable memory (`sp_memory`). It accepts word read and write requests over a valid/ready interface and drives the memory's `cs`/`we`/`addr`/`wdata`/`wstrb` pins. It absorbs the memory's one-cycle synchronous read latency and buffers read data so that downstream backpressure never loses a response. It sits directly upstream of the memory and below any bus slave or DMA engine.

## Interface
- `WIDTH`, 32: data width in bits; must be a multiple of 8; equals the memory `WIDTH`.
- `DEPTH`, 1024: memory depth in words; equals the memory `DEPTH`. `AW` = `$clog2(DEPTH)`.
- `clk` in 1: single clock for the block and the memory.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in AW: word address.
- `req_wdata` in WIDTH: write data.
- `req_wstrb` in WIDTH/8: byte enables; ignored for reads.
- `rsp_valid` out 1: read response present.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata` out WIDTH: read data.
- `init_done` out 1: the block is accepting requests.
- `mem_cs`, `mem_we` out 1: memory chip select and write enable.
- `mem_addr` out AW; `mem_wdata` out WIDTH; `mem_wstrb` out WIDTH/8: memory controls.
- `mem_rdata` in WIDTH: memory read data, valid one cycle after `mem_cs && !mem_we`.

## Operation
- The state machine has two states, `ST_INIT` and `ST_RUN`.
  - Reset enters `ST_INIT` if `SP_MEM_CTRL_INIT_EN` is defined, otherwise `ST_RUN`.
  - `ST_INIT` moves to `ST_RUN` after the last init write.
- In `ST_RUN`, the memory pins are combinational from the request:
  - `mem_cs = req_valid && req_ready && (req_addr < DEPTH)`.
  - `mem_we = req_we`, and `mem_addr`/`mem_wdata`/`mem_wstrb` pass through from the request.
- Writes never generate a response.
- Reads go through a 2-entry response FIFO, ordered by acceptance.
  - `occ` is the FIFO occupancy (0..2).
  - `infl` is 1 if a read was accepted in the previous cycle.
  - `pop` is `rsp_valid && rsp_ready`.
- `req_ready` rules:
  - `req_ready = (state == ST_RUN) && (req_we || (occ + infl - pop) < 2)`.
  - `req_ready` may depend combinationally on `rsp_ready`.
- Read data path:
  - The cycle after a read is accepted, `mem_rdata` is pushed into the FIFO.
  - `rsp_valid = (occ != 0)`; `rsp_rdata` is the FIFO head.
- Out-of-range address (`req_addr >= DEPTH`, possible only for non-power-of-2 `DEPTH`):
  - The request is accepted with no memory access.
  - A write is dropped.
  - A read pushes all-zeros in place of `mem_rdata`.
- Push and pop in the same cycle at `occ` = 2 is legal; `occ` stays 2.
- A read following a write to the same address on the next cycle returns the new data (the memory writes at the edge).
- Reset mid-operation discards in-flight reads and FIFO contents.

## Timing
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `mem_cs` = 0, `mem_we` = 0.
  - `init_done` = 0 with `SP_MEM_CTRL_INIT_EN`, 1 without it.
- Write latency: the memory is updated at the edge ending the accept cycle N.
- Read latency: accept in cycle N gives `rsp_valid` in cycle N+2 when the FIFO is empty.
- Throughput: with `rsp_ready` held at 1, one read or write is accepted per cycle indefinitely.
- `rsp_valid`/`rsp_rdata` are registered and must hold stable until `pop`.

## Configuration
- `SP_MEM_CTRL_INIT_EN` defined:
  - After reset, `ST_INIT` writes all-zeros with full `wstrb` to addresses 0..DEPTH-1, one per cycle.
  - `req_ready` is 0 throughout `ST_INIT`.
  - `init_done` rises in cycle DEPTH (counting the first cycle after reset release as 0) and stays high until the next reset.
- `SP_MEM_CTRL_INIT_EN` undefined:
  - There is no init sweep or address counter logic.
  - `ST_RUN` is entered from reset and `init_done` is constant 1.

## Structure
- The package `sp_mem_ctrl_pkg` holds:
  - the state typedef `sp_mem_ctrl_state_e` (`ST_INIT`, `ST_RUN`);
  - the localparam `RSP_DEPTH` = 2.
- The sub-module `sp_mem_ctrl_rsp_fifo` is a 2-entry synchronous FIFO, parameterized by `WIDTH`, exposing push, pop, `occ` and head.
- The top module holds the state machine, credit logic, init counter, and memory pin muxing.

## Test plan
- Write `0xDEADBEEF` to addr 5 with `wstrb` = `4'b1111`, then read addr 5 → `rsp_rdata` = `0xDEADBEEF`, `rsp_valid` rising 2 cycles after read accept.
- Write `0x11223344` to addr 7 with `wstrb` = `4'b1111`, then write `0xAABBCCDD` with `wstrb` = `4'b0101`, then read addr 7 → `0x11BB33DD`.
- Hold `rsp_ready` = 0 and issue 4 back-to-back reads of addrs 0..3 → exactly 2 accepted, `req_ready` stays 0. Then raise `rsp_ready` → 4 responses arrive in order with no loss.
- With `rsp_ready` = 1, issue 16 consecutive reads → 16 accepts in 16 cycles, and responses appear on 16 consecutive cycles.
- With `SP_MEM_CTRL_INIT_EN` and `DEPTH` = 16:
  - preload memory with nonzero data, then reset → `init_done` rises in cycle 16, and reads of addrs 0..15 return 0;
  - assert `rst_n` = 0 with 2 responses pending → `rsp_valid` = 0 immediately.
- With `DEPTH` = 12, write addr 13 then read addr 13 → no `mem_cs` pulse, and the read response is 0.
